// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic {
    IDLE,
    WAIT_RSP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 5;

endpackage : lsu_pkg

// File: rtl/lsu_align.sv
// Combinational store-lane steering and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    be        = 4'b1111;
    wdata     = store_data;
    load_data = load_raw;
    load_byte = load_raw[{addr_lo, 3'b000} +: 8];
    load_half = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];

    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{(funct3 == F3_B) & load_byte[7]}}, load_byte};
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{(funct3 == F3_H) & load_half[15]}}, load_half};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = load_raw;
      end
    endcase
  end

endmodule : lsu_align

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt + rvalid bus master with pipeline stall and timeout.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_read_data_out,
  output logic        stall_out,
  output logic        bus_err_out,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign_exc_out,
`endif
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_store, is_load;
  logic [3:0]       steer_be;
  logic [31:0]      steer_wdata, load_data;

  // A simultaneous read+write is resolved as a store.
  assign is_store = valid_in & mem_write_in;
  assign is_load  = valid_in & mem_read_in & ~mem_write_in;

  assign alu_result_out = alu_result_in;
  assign dmem_addr      = {alu_result_in[31:2], 2'b00};
  assign dmem_be        = steer_be;
  assign dmem_wdata     = steer_wdata;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (((funct3_in == F3_H) || (funct3_in == F3_HU)) && alu_result_in[0])
                   || ((funct3_in == F3_W) && (alu_result_in[1:0] != 2'b00));
`endif

  lsu_align u_align (
    .funct3     (funct3_in),
    .addr_lo    (alu_result_in[1:0]),
    .store_data (write_data_in),
    .load_raw   (dmem_rdata),
    .be         (steer_be),
    .wdata      (steer_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    stall_out         = 1'b0;
    bus_err_out       = 1'b0;
    mem_read_data_out = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_exc_out  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (is_store || is_load) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) misalign_exc_out = 1'b1;
          else
`endif
          begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (is_store) begin
              stall_out = ~dmem_gnt;
            end else begin
              stall_out = 1'b1;
              if (dmem_gnt) begin
                state_d = WAIT_RSP;
                cnt_d   = '0;
              end
            end
          end
        end
      end

      WAIT_RSP: begin
        if (dmem_rvalid) begin
          mem_read_data_out = load_data;
          state_d           = IDLE;
          cnt_d             = '0;
        end else if (cnt_q == LAST_CNT) begin
          // Abandon the access: let the pipeline move on with zero data.
          bus_err_out = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end else begin
          stall_out = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are quiet the instant reset asserts, whatever the inputs show.
    if (!reset_n) begin
      dmem_req          = 1'b0;
      dmem_we           = 1'b0;
      stall_out         = 1'b0;
      bus_err_out       = 1'b0;
      mem_read_data_out = '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_exc_out  = 1'b0;
`endif
    end
  end

endmodule : mem_stage_lsu

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, corner sequences, random transactions.
module tb_mem_stage_lsu;

  localparam int TO_CYCLES = 16;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, mem_read_in, mem_write_in;
  logic [31:0] alu_result_in, write_data_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_out, mem_read_data_out;
  logic        stall_out, bus_err_out;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_exc_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clock             (clk),
    .reset_n           (rst_n),
    .valid_in          (valid_in),
    .alu_result_in     (alu_result_in),
    .write_data_in     (write_data_in),
    .funct3_in         (funct3_in),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .alu_result_out    (alu_result_out),
    .mem_read_data_out (mem_read_data_out),
    .stall_out         (stall_out),
    .bus_err_out       (bus_err_out),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_exc_out  (misalign_exc_out),
`endif
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_be           (dmem_be),
    .dmem_wdata        (dmem_wdata),
    .dmem_gnt          (dmem_gnt),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: arithmetic view of lane selection and extension.
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned a = addr % 4;
    if (f3 == B || f3 == BU) return 4'(2 ** a);
    if (f3 == H || f3 == HU) return 4'(3 * (2 ** ((a / 2) * 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == B || f3 == BU) return (wd % 256) * 32'h0101_0101;
    if (f3 == H || f3 == HU) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int unsigned a = addr % 4;
    logic [31:0] v;
    if (f3 == B || f3 == BU) begin
      v = (rd / (2 ** (8 * a))) % 256;
      if (f3 == B && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (f3 == H || f3 == HU) begin
      v = (rd / (2 ** (16 * (a / 2)))) % 65536;
      if (f3 == H && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic present(input logic st, input logic both, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    valid_in = 1'b1; mem_write_in = st; mem_read_in = st ? both : 1'b1;
    funct3_in = f3; alu_result_in = addr; write_data_in = wd;
  endtask

  // One transaction: gnt after g stalled cycles; for loads rvalid after r WAIT cycles.
  task automatic run_txn(input string tag, input logic st, input logic both, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int g, input int r);
    present(st, both, f3, addr, wd);
    for (int c = 0; c <= g; c++) begin
      dmem_gnt = (c == g); dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      #3;
      check({tag, " req"}, 32'(dmem_req), 32'd1);
      check({tag, " we"}, 32'(dmem_we), 32'(st));
      check({tag, " addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
      check({tag, " alu_out"}, alu_result_out, addr);
      check({tag, " req stall"}, 32'(stall_out), (st && c == g) ? 32'd0 : 32'd1);
      check({tag, " req data"}, mem_read_data_out, 32'd0);
      if (st && c == g) begin
        check({tag, " be"}, 32'(dmem_be), 32'(m_be(f3, addr)));
        check({tag, " wdata"}, dmem_wdata, m_wdata(f3, wd));
      end
      tick();
    end
    if (!st) begin
      for (int c = 0; c <= r; c++) begin
        dmem_gnt = 1'($urandom_range(0, 1)); dmem_rvalid = (c == r);
        dmem_rdata = (c == r) ? rd : $urandom;
        #3;
        check({tag, " wait req"}, 32'(dmem_req), 32'd0);
        check({tag, " wait stall"}, 32'(stall_out), (c == r) ? 32'd0 : 32'd1);
        check({tag, " wait err"}, 32'(bus_err_out), 32'd0);
        check({tag, " load data"}, mem_read_data_out, (c == r) ? m_load(f3, addr, rd) : 32'd0);
        tick();
      end
    end
    idle_inputs();
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, B,  32'h103, 32'h0, 32'h8012_3456, 4'h0, 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b0, BU, 32'h103, 32'h0, 32'h8012_3456, 4'h0, 32'h0, 32'h0000_0080};
    vecs[2]  = '{1'b0, HU, 32'h102, 32'h0, 32'h8012_3456, 4'h0, 32'h0, 32'h0000_8012};
    vecs[3]  = '{1'b0, H,  32'h102, 32'h0, 32'h8012_3456, 4'h0, 32'h0, 32'hFFFF_8012};
    vecs[4]  = '{1'b0, H,  32'h100, 32'h0, 32'h8012_3456, 4'h0, 32'h0, 32'h0000_3456};
    vecs[5]  = '{1'b0, W,  32'h100, 32'h0, 32'hDEAD_BEEF, 4'h0, 32'h0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, B,  32'h101, 32'h0, 32'h8012_3456, 4'h0, 32'h0, 32'h0000_0034};
    vecs[7]  = '{1'b1, B,  32'h102, 32'h0000_00AB, 32'h0, 4'b0100, 32'hABAB_ABAB, 32'h0};
    vecs[8]  = '{1'b1, H,  32'h102, 32'h1234_CAFE, 32'h0, 4'b1100, 32'hCAFE_CAFE, 32'h0};
    vecs[9]  = '{1'b1, W,  32'h104, 32'h0102_0304, 32'h0, 4'b1111, 32'h0102_0304, 32'h0};
    vecs[10] = '{1'b1, B,  32'h101, 32'h0000_0055, 32'h0, 4'b0010, 32'h5555_5555, 32'h0};

    rst_n = 1'b0;
    idle_inputs();
    funct3_in = W; alu_result_in = '0; write_data_in = '0; dmem_rdata = '0;
    #2;
    check("reset req", 32'(dmem_req), 32'd0);
    check("reset stall", 32'(stall_out), 32'd0);
    check("reset err", 32'(bus_err_out), 32'd0);
    check("reset data", mem_read_data_out, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Idle pass-through with a stray rvalid.
    alu_result_in = 32'h1234_5678; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #3;
    check("idle req", 32'(dmem_req), 32'd0);
    check("idle stall", 32'(stall_out), 32'd0);
    check("idle alu_out", alu_result_out, 32'h1234_5678);
    check("idle data", mem_read_data_out, 32'd0);
    tick();
    idle_inputs();

    // Directed vector table, single-cycle gnt and rvalid.
    for (int i = 0; i < 11; i++) begin
      present(vecs[i].st, 1'b0, vecs[i].f3, vecs[i].addr, vecs[i].wd);
      dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
      #3;
      check($sformatf("vec%0d req", i), 32'(dmem_req), 32'd1);
      check($sformatf("vec%0d addr", i), dmem_addr, vecs[i].addr & 32'hFFFF_FFFC);
      if (vecs[i].st) begin
        check($sformatf("vec%0d stall", i), 32'(stall_out), 32'd0);
        check($sformatf("vec%0d be", i), 32'(dmem_be), 32'(vecs[i].be));
        check($sformatf("vec%0d wdata", i), dmem_wdata, vecs[i].wdata);
        tick();
      end else begin
        check($sformatf("vec%0d stall", i), 32'(stall_out), 32'd1);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = vecs[i].rd;
        #3;
        check($sformatf("vec%0d rsp stall", i), 32'(stall_out), 32'd0);
        check($sformatf("vec%0d load", i), mem_read_data_out, vecs[i].load);
        tick();
      end
      idle_inputs();
    end

    // LW 0x100: gnt in cycle 1, rvalid in cycle 3.
    present(1'b0, 1'b0, W, 32'h100, 32'h0);
    dmem_gnt = 1'b1; #3;
    check("lw c1 stall", 32'(stall_out), 32'd1);
    tick();
    dmem_gnt = 1'b0; #3;
    check("lw c2 stall", 32'(stall_out), 32'd1);
    check("lw c2 req", 32'(dmem_req), 32'd0);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #3;
    check("lw c3 stall", 32'(stall_out), 32'd0);
    check("lw c3 data", mem_read_data_out, 32'hDEAD_BEEF);
    tick();
    idle_inputs();

    // Timeout: no rvalid, error pulse in WAIT cycle 16, late rvalid ignored.
    present(1'b0, 1'b0, W, 32'h100, 32'h0);
    dmem_gnt = 1'b1; #3;
    check("to issue stall", 32'(stall_out), 32'd1);
    tick();
    dmem_gnt = 1'b0;
    for (int k = 1; k <= TO_CYCLES; k++) begin
      #3;
      check($sformatf("to w%0d err", k), 32'(bus_err_out), (k == TO_CYCLES) ? 32'd1 : 32'd0);
      check($sformatf("to w%0d stall", k), 32'(stall_out), (k == TO_CYCLES) ? 32'd0 : 32'd1);
      check($sformatf("to w%0d data", k), mem_read_data_out, 32'd0);
      tick();
    end
    idle_inputs();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #3;
    check("to late err", 32'(bus_err_out), 32'd0);
    check("to late data", mem_read_data_out, 32'd0);
    check("to late stall", 32'(stall_out), 32'd0);
    tick();
    idle_inputs();

    // Misaligned LW 0x102.
    present(1'b0, 1'b0, W, 32'h102, 32'h0);
    dmem_gnt = 1'b0; #3;
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis exc", 32'(misalign_exc_out), 32'd1);
    check("mis req", 32'(dmem_req), 32'd0);
    check("mis stall", 32'(stall_out), 32'd0);
    check("mis data", mem_read_data_out, 32'd0);
    tick();
`else
    check("mis req", 32'(dmem_req), 32'd1);
    check("mis addr", dmem_addr, 32'h100);
    check("mis be", 32'(dmem_be), 32'hF);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D; #3;
    check("mis data", mem_read_data_out, 32'h0BAD_F00D);
    tick();
`endif
    idle_inputs();

    // Reset asserted mid-WAIT_RSP while the load is still presented.
    present(1'b0, 1'b0, W, 32'h200, 32'h0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    rst_n = 1'b0; #3;
    check("rst mid req", 32'(dmem_req), 32'd0);
    check("rst mid stall", 32'(stall_out), 32'd0);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678; #3;
    check("rst rvalid data", mem_read_data_out, 32'd0);
    check("rst rvalid stall", 32'(stall_out), 32'd0);
    tick();
    idle_inputs();

    // Random transactions against the model.
    for (int n = 0; n < 200; n++) begin
      logic        st, both;
      logic [2:0]  f3;
      logic [31:0] addr;
      case ($urandom_range(0, 4))
        0: f3 = B; 1: f3 = H; 2: f3 = W; 3: f3 = BU; default: f3 = HU;
      endcase
      st   = 1'($urandom_range(0, 1));
      both = 1'($urandom_range(0, 1));
      if (st && (f3 == BU || f3 == HU)) f3 = (f3 == BU) ? B : H;
      addr = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      if (f3 == H || f3 == HU) addr[0] = 1'b0;
      if (f3 == W) addr[1:0] = 2'b00;
`endif
      run_txn($sformatf("rnd%0d", n), st, both, f3, addr, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) begin
        dmem_rvalid = 1'b1; dmem_rdata = $urandom; #3;
        check($sformatf("rnd%0d gap data", n), mem_read_data_out, 32'd0);
        check($sformatf("rnd%0d gap stall", n), 32'(stall_out), 32'd0);
        tick();
        idle_inputs();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_stage_lsu
